day10_press_solver: RTL and testbench
=====================================

# day10_press_solver

Streaming GF(2) minimum-press solver for the day-10 indicator-light puzzle, parametrised in light and button count. Each accepted beat carries one machine: a target light pattern and up to MAX_BUTTONS toggle masks. The block enumerates every button subset in Gray-code order, finds the fewest presses whose XOR equals the target, and accumulates the per-machine minimum into a running total. It sits between the input parser/ROM streamer and the top-level `solution` result registers, and replaces the fixed-size single-machine search.

## Interface
- MAX_LIGHTS, 16, width of target and each button mask
- MAX_BUTTONS, 16, max buttons per machine; search cost 2^N cycles
- SUM_W, 64, width of total_presses
- NW (localparam), $clog2(MAX_BUTTONS+1), width of button-count and press-count fields
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  machine beat valid
- in_ready  out  1  block can accept a beat
- in_last  in  1  beat is the final machine
- in_target  in  MAX_LIGHTS  required light pattern, bit i = light i
- in_btn_count  in  NW  number of valid buttons N, 0..MAX_BUTTONS
- in_btn_masks  in  MAX_BUTTONS*MAX_LIGHTS  mask j at bits [j*MAX_LIGHTS +: MAX_LIGHTS]
- total_presses  out  SUM_W  sum of minima of solvable machines
- unsolved_count  out  16  machines with no solution
- done  out  1  high after last machine committed, held until reset

## Operation
- FSM states: IDLE, SEARCH, COMMIT, DONE.
- IDLE: in_ready=1. Handshake on in_valid&&in_ready: latch target, masks, N, last; cur=0, gray=0, weight=0, k=1; best = (target==0) ? 0 : SENTINEL (all ones, NW bits). Go to SEARCH if N>0, otherwise COMMIT.
- SEARCH: in_ready=0. Each cycle: idx=ctz(k); gray[idx] flips; weight_next = weight ± 1 (−1 if gray[idx] was 1); cur_next = cur ^ mask[idx]. If cur_next==target and weight_next<best, then best=weight_next. After k==2^N−1, go to COMMIT; otherwise k++.
- COMMIT: if best!=SENTINEL, total_presses += best (wraps mod 2^SUM_W); else unsolved_count++ (saturates at 0xFFFF). Go to DONE if last, else IDLE.
- DONE: in_ready=0, done=1; inputs are ignored.
- Mask slots j≥N are ignored. Producer guarantees target bits above the real light count are 0.

## Timing
- Reset values: in_ready=0 while rst is high, 1 in IDLE from the first cycle after release. total_presses=0, unsolved_count=0, done=0, FSM in IDLE.
- Machine occupancy: 2^N+1 cycles from accept edge to in_ready high again (1 accept, 2^N−1 search, 1 commit). N=0 takes 2 cycles.
- total_presses is updated at the COMMIT edge. done rises at the same edge as the last machine's commit.
- in_valid may be held with the data changing only after the handshake. in_ready never depends combinationally on in_valid.
- Reset asserted mid-SEARCH or mid-COMMIT: all state is cleared immediately. The partial machine is discarded and no commit occurs.

## Configuration
- DAY10_RESULT_STREAM_EN defined: adds outputs res_valid (1), res_presses (NW) and res_solved (1). These form a one-cycle pulse in COMMIT carrying best (SENTINEL if unsolved). There is no backpressure. All three are 0 out of reset.
- Undefined: the ports do not exist, and behaviour is otherwise identical.

## Structure
- Package day10_pkg holds:
  - the state enum
  - MAX_LIGHTS/MAX_BUTTONS defaults
  - the NW function
  - the SENTINEL constant
- Sub-module day10_ctz: combinational count-trailing-zeros / priority encoder of width MAX_BUTTONS, output NW bits. It is the only natural split.

## Test plan
- Target 4'b0110 with masks 1000, 1010, 0100, 1100, 0101, 0011 (N=6), last=1 -> total_presses=2, done 65 cycles after accept, unsolved_count=0.
- The three published example machines streamed back-to-back with in_valid held high -> total_presses=7, done=1, in_ready low for exactly 2^N−1+1 cycles after each accept.
- Target 0 with N=4 arbitrary masks -> minimum 0, total unchanged, 17-cycle occupancy. Then N=0 with target 4'b0001 -> unsolved_count=1, total unchanged.
- Target 4'b0011 with masks 0001 and 0010 only (N=2) -> 2. Same target with masks 0001 and 0001 -> unsolved. Checks that the search reaches k=2^N−1 and uses the right sentinel compare.
- Reset pulsed 10 cycles into an N=10 search -> outputs return to reset values asynchronously. A fresh machine afterwards gives a correct total and no stale commit.
- With DAY10_RESULT_STREAM_EN, the first scenario -> single res_valid pulse, res_presses=2, res_solved=1. Without the macro, the bench compiles with the ports absent.

Source files
------------

// File: rtl/day10_pkg.sv
// Shared types and constants for the day-10 minimum-press solver.
package day10_pkg;

    // Solver control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEF_MAX_LIGHTS  = 16;
    localparam int DEF_MAX_BUTTONS = 16;

    // Width that can hold any count from 0 up to max_buttons inclusive.
    function automatic int nw_of(input int max_buttons);
        return $clog2(max_buttons + 1);
    endfunction

    localparam int DEF_NW = nw_of(DEF_MAX_BUTTONS);

    // "No solution found yet" marker: all ones in an NW-bit field, always
    // larger than any real press count.
    localparam logic [DEF_NW-1:0] SENTINEL = '1;

endpackage

// File: rtl/day10_ctz.sv
// Count-trailing-zeros / lowest-set-bit priority encoder.
// Returns the index of the lowest set bit of i_vec; an all-zero input
// yields 0 (the solver never presents zero).
module day10_ctz
    import day10_pkg::*;
#(
    parameter int W = DEF_MAX_BUTTONS,
    localparam int OW = nw_of(W)
)(
    input  logic [W-1:0]  i_vec,
    output logic [OW-1:0] o_idx
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        o_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = OW'(i);
            end
        end
    end

endmodule

// File: rtl/day10_press_solver.sv
// Streaming GF(2) minimum-press solver. One machine per accepted beat;
// every button subset is visited in Gray-code order so each step toggles
// exactly one button, and the smallest matching subset weight is added to
// a running total.
// Optional build macro: DAY10_RESULT_STREAM_EN adds a per-machine result
// pulse (res_valid / res_presses / res_solved).
module day10_press_solver
    import day10_pkg::*;
#(
    parameter int MAX_LIGHTS  = DEF_MAX_LIGHTS,
    parameter int MAX_BUTTONS = DEF_MAX_BUTTONS,
    parameter int SUM_W       = 64,
    localparam int NW         = nw_of(MAX_BUTTONS)
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    input  logic [MAX_LIGHTS-1:0]           in_target,
    input  logic [NW-1:0]                   in_btn_count,
    input  logic [MAX_BUTTONS*MAX_LIGHTS-1:0] in_btn_masks,
    output logic [SUM_W-1:0]                total_presses,
    output logic [15:0]                     unsolved_count,
    output logic                            done
`ifdef DAY10_RESULT_STREAM_EN
    ,
    output logic                            res_valid,
    output logic [NW-1:0]                   res_presses,
    output logic                            res_solved
`endif
);

    // Mask table is padded to the full index range of the ctz output so
    // the lookup never needs a range check.
    localparam int TBL_DEPTH = 1 << NW;
    localparam logic [NW-1:0]          LOCAL_SENTINEL = '1;
    localparam logic [NW-1:0]          NW_ONE   = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [MAX_BUTTONS-1:0] K_ONE    = {{(MAX_BUTTONS-1){1'b0}}, 1'b1};
    localparam logic [MAX_BUTTONS:0]   SPAN_ONE = {{MAX_BUTTONS{1'b0}}, 1'b1};

    state_e                          r_state;
    logic [MAX_LIGHTS-1:0]           r_target;
    logic [MAX_LIGHTS-1:0]           r_cur;
    logic [MAX_BUTTONS*MAX_LIGHTS-1:0] r_masks;
    logic [NW-1:0]                   r_n;
    logic [NW-1:0]                   r_weight;
    logic [NW-1:0]                   r_best;
    logic                            r_last;
    logic                            r_done;
    logic [MAX_BUTTONS-1:0]          r_gray;
    logic [MAX_BUTTONS-1:0]          r_k;
    logic [SUM_W-1:0]                r_total;
    logic [15:0]                     r_unsolved;

    logic [MAX_LIGHTS-1:0]           w_mask_tbl [0:TBL_DEPTH-1];
    logic [NW-1:0]                   w_idx;
    logic [MAX_LIGHTS-1:0]           w_sel_mask;
    logic [MAX_BUTTONS-1:0]          w_low_bit;
    logic                            w_was_set;
    logic [NW-1:0]                   w_weight_next;
    logic [MAX_LIGHTS-1:0]           w_cur_next;
    logic [MAX_BUTTONS:0]            w_span;
    logic                            w_k_last;
    logic                            w_hit;

    // Unpack the latched masks; slots beyond MAX_BUTTONS read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < TBL_DEPTH; gi++) begin : g_mask_tbl
            if (gi < MAX_BUTTONS) begin : g_real
                assign w_mask_tbl[gi] = r_masks[gi*MAX_LIGHTS +: MAX_LIGHTS];
            end else begin : g_pad
                assign w_mask_tbl[gi] = '0;
            end
        end
    endgenerate

    // Gray-code step k toggles button ctz(k).
    day10_ctz #(
        .W (MAX_BUTTONS)
    ) u_ctz (
        .i_vec (r_k),
        .o_idx (w_idx)
    );

    assign w_sel_mask    = w_mask_tbl[w_idx];
    assign w_low_bit     = r_k & (~r_k + K_ONE);
    assign w_was_set     = |(r_gray & w_low_bit);
    assign w_weight_next = w_was_set ? (r_weight - NW_ONE) : (r_weight + NW_ONE);
    assign w_cur_next    = r_cur ^ w_sel_mask;
    // Final step is k == 2^N - 1; computed one bit wider so N == MAX_BUTTONS fits.
    assign w_span        = (SPAN_ONE << r_n) - SPAN_ONE;
    assign w_k_last      = ({1'b0, r_k} == w_span);
    assign w_hit         = (w_cur_next == r_target) && (w_weight_next < r_best);

    // Ready is forced low while reset is held so no beat is taken in reset.
    assign in_ready       = (r_state == ST_IDLE) && !rst;
    assign total_presses  = r_total;
    assign unsolved_count = r_unsolved;
    assign done           = r_done;

    // Accept, Gray-code search, commit and terminal hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_target   <= '0;
            r_cur      <= '0;
            r_masks    <= '0;
            r_n        <= '0;
            r_weight   <= '0;
            r_best     <= '0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_gray     <= '0;
            r_k        <= '0;
            r_total    <= '0;
            r_unsolved <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_target <= in_target;
                        r_masks  <= in_btn_masks;
                        r_n      <= in_btn_count;
                        r_last   <= in_last;
                        r_cur    <= '0;
                        r_gray   <= '0;
                        r_weight <= '0;
                        r_k      <= K_ONE;
                        // The empty subset already solves an all-off target.
                        r_best   <= (in_target == '0) ? '0 : LOCAL_SENTINEL;
                        r_state  <= (in_btn_count == '0) ? ST_COMMIT : ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    r_cur    <= w_cur_next;
                    r_gray   <= r_gray ^ w_low_bit;
                    r_weight <= w_weight_next;
                    if (w_hit) begin
                        r_best <= w_weight_next;
                    end
                    if (w_k_last) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_k <= r_k + K_ONE;
                    end
                end
                ST_COMMIT: begin
                    if (r_best != LOCAL_SENTINEL) begin
                        r_total <= r_total + {{(SUM_W-NW){1'b0}}, r_best};
                    end else if (r_unsolved != 16'hFFFF) begin
                        r_unsolved <= r_unsolved + 16'd1;
                    end
                    if (r_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DAY10_RESULT_STREAM_EN
    // One-cycle result pulse while the machine is being committed.
    always_comb begin
        res_valid   = (r_state == ST_COMMIT);
        res_presses = res_valid ? r_best : '0;
        res_solved  = res_valid && (r_best != LOCAL_SENTINEL);
    end
`endif

endmodule

// File: tb/tb_day10_press_solver.sv
// Self-checking bench for day10_press_solver. Expected minima come from a
// brute-force subset enumeration; optional DAY10_RESULT_STREAM_EN ports are
// connected and checked only when the macro is defined.
module tb_day10_press_solver;
    import day10_pkg::*;

    localparam int ML = 16;
    localparam int MB = 16;
    localparam int NW = nw_of(MB);
    localparam int SW = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [ML-1:0]    in_target;
    logic [NW-1:0]    in_btn_count;
    logic [MB*ML-1:0] in_btn_masks;
    logic [SW-1:0]    total_presses;
    logic [15:0]      unsolved_count;
    logic             done;
`ifdef DAY10_RESULT_STREAM_EN
    logic             res_valid;
    logic [NW-1:0]    res_presses;
    logic             res_solved;
`endif

    day10_press_solver #(
        .MAX_LIGHTS  (ML),
        .MAX_BUTTONS (MB),
        .SUM_W       (SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_last        (in_last),
        .in_target      (in_target),
        .in_btn_count   (in_btn_count),
        .in_btn_masks   (in_btn_masks),
        .total_presses  (total_presses),
        .unsolved_count (unsolved_count),
        .done           (done)
`ifdef DAY10_RESULT_STREAM_EN
        ,
        .res_valid      (res_valid),
        .res_presses    (res_presses),
        .res_solved     (res_solved)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] m_total;
    int          m_unsolved;
    logic [15:0] mm [16];

    int            pulse_cnt = 0;
    logic [NW-1:0] pulse_presses = '0;
    logic          pulse_solved = 1'b0;
`ifdef DAY10_RESULT_STREAM_EN
    // Capture result pulses mid-cycle.
    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            pulse_cnt     = pulse_cnt + 1;
            pulse_presses = res_presses;
            pulse_solved  = res_solved;
        end
    end
`endif

    // Brute force over all 2^n subsets: fewest buttons whose XOR equals t, -1 if none.
    function automatic int ref_min(input logic [15:0] t, input int n, input logic [15:0] m [16]);
        int best;
        best = 1000;
        for (int s = 0; s < (1 << n); s++) begin
            logic [15:0] acc;
            int pc;
            acc = '0;
            pc  = 0;
            for (int j = 0; j < n; j++) begin
                if (s[j]) begin
                    acc = acc ^ m[j];
                    pc++;
                end
            end
            if (acc == t && pc < best) best = pc;
        end
        return (best == 1000) ? -1 : best;
    endfunction

    task automatic model_apply(input int r);
        if (r >= 0) m_total = m_total + 64'(r);
        else        m_unsolved++;
    endtask

    // Present one machine, wait for the handshake, then count cycles until
    // the block is ready again (or done). Called just after a falling edge.
    task automatic send(input logic [15:0] t, input int n, input logic [15:0] m [16],
                        input bit last, input bit hold, output int busy);
        int w;
        in_target    = t;
        in_btn_count = NW'(n);
        for (int j = 0; j < 16; j++) in_btn_masks[j*16 +: 16] = m[j];
        in_last  = last;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
            in_valid = 1'b0;
            busy = -1;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        busy = 0;
        @(negedge clk);
        while (!in_ready && !done && busy < 2000) begin
            busy++;
            @(negedge clk);
        end
        if (busy >= 2000) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout busy=%0d required<2000", busy);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_target = '0;
        in_btn_count = '0;
        in_btn_masks = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", in_ready); end
        checks++; if (total_presses !== 64'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", total_presses); end
        checks++; if (unsolved_count !== 16'd0) begin failures++; $display("FAIL reset_unsolved got=%0d exp=0", unsolved_count); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
`ifdef DAY10_RESULT_STREAM_EN
        checks++; if ({res_valid, res_presses, res_solved} !== '0) begin failures++; $display("FAIL reset_stream got=%0b/%0d/%0b exp=0/0/0", res_valid, res_presses, res_solved); end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%0b exp=1", in_ready); end
        m_total    = '0;
        m_unsolved = 0;
        $display("reset: total=%0d unsolved=%0d ready=%0b", total_presses, unsolved_count, in_ready);
    endtask

    task automatic test_example1();
        int busy, r, p0;
        p0 = pulse_cnt;
        mm[0] = 16'b1000; mm[1] = 16'b1010; mm[2] = 16'b0100;
        mm[3] = 16'b1100; mm[4] = 16'b0101; mm[5] = 16'b0011;
        for (int j = 6; j < 16; j++) mm[j] = 16'($urandom);
        send(16'b0110, 6, mm, 1'b1, 1'b0, busy);
        r = ref_min(16'b0110, 6, mm);
        model_apply(r);
        $display("example1: n=6 busy=%0d total=%0d done=%0b", busy, total_presses, done);
        checks++; if (total_presses !== 64'd2) begin failures++; $display("FAIL ex1_total got=%0d exp=2", total_presses); end
        checks++; if (busy !== 64) begin failures++; $display("FAIL ex1_latency got=%0d exp=64", busy); end
        checks++; if (unsolved_count !== 16'd0) begin failures++; $display("FAIL ex1_unsolved got=%0d exp=0", unsolved_count); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ex1_done got=%0b exp=1", done); end
`ifdef DAY10_RESULT_STREAM_EN
        checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL ex1_pulses got=%0d exp=1", pulse_cnt - p0); end
        checks++; if (pulse_presses !== NW'(2)) begin failures++; $display("FAIL ex1_res_presses got=%0d exp=2", pulse_presses); end
        checks++; if (pulse_solved !== 1'b1) begin failures++; $display("FAIL ex1_res_solved got=%0b exp=1", pulse_solved); end
`endif
        // Inputs must be ignored once done.
        in_target = 16'b0001; in_btn_count = NW'(1); in_btn_masks = '1; in_last = 1'b0;
        in_valid = 1'b1;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        $display("done_hold: ready=%0b total=%0d done=%0b", in_ready, total_presses, done);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL done_ready got=%0b exp=0", in_ready); end
        checks++; if (total_presses !== m_total) begin failures++; $display("FAIL done_total got=%0d exp=%0d", total_presses, m_total); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_hold got=%0b exp=1", done); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] t [3];
        int n [3];
        logic [15:0] ms [3][16];
        int busy, r;
        t[0] = 16'b0110;   n[0] = 6;
        ms[0][0] = 16'b1000; ms[0][1] = 16'b1010; ms[0][2] = 16'b0100;
        ms[0][3] = 16'b1100; ms[0][4] = 16'b0101; ms[0][5] = 16'b0011;
        t[1] = 16'b01000;  n[1] = 5;
        ms[1][0] = 16'b11101; ms[1][1] = 16'b01100; ms[1][2] = 16'b10001;
        ms[1][3] = 16'b00111; ms[1][4] = 16'b11110;
        t[2] = 16'b101110; n[2] = 4;
        ms[2][0] = 16'b011111; ms[2][1] = 16'b011001;
        ms[2][2] = 16'b110111; ms[2][3] = 16'b000110;
        for (int i = 0; i < 3; i++) begin
            for (int j = n[i]; j < 16; j++) ms[i][j] = 16'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 16; j++) mm[j] = ms[i][j];
            send(t[i], n[i], mm, i == 2, 1'b1, busy);
            r = ref_min(t[i], n[i], mm);
            model_apply(r);
            $display("b2b[%0d]: n=%0d min=%0d busy=%0d total=%0d", i, n[i], r, busy, total_presses);
            checks++; if (busy !== (1 << n[i])) begin failures++; $display("FAIL b2b_busy[%0d] got=%0d exp=%0d", i, busy, 1 << n[i]); end
            checks++; if (total_presses !== m_total) begin failures++; $display("FAIL b2b_total[%0d] got=%0d exp=%0d", i, total_presses, m_total); end
        end
        in_valid = 1'b0;
        checks++; if (total_presses !== 64'd7) begin failures++; $display("FAIL b2b_sum got=%0d exp=7", total_presses); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%0b exp=1", done); end
    endtask

    task automatic test_zero_and_empty();
        int busy, r, p0;
        for (int j = 0; j < 16; j++) mm[j] = 16'($urandom);
        send(16'd0, 4, mm, 1'b0, 1'b0, busy);
        r = ref_min(16'd0, 4, mm);
        model_apply(r);
        $display("zero_target: n=4 busy=%0d total=%0d", busy, total_presses);
        checks++; if (busy !== 16) begin failures++; $display("FAIL zero_busy got=%0d exp=16", busy); end
        checks++; if (total_presses !== m_total) begin failures++; $display("FAIL zero_total got=%0d exp=%0d", total_presses, m_total); end
        p0 = pulse_cnt;
        send(16'b0001, 0, mm, 1'b0, 1'b0, busy);
        r = ref_min(16'b0001, 0, mm);
        model_apply(r);
        $display("empty: n=0 busy=%0d unsolved=%0d total=%0d", busy, unsolved_count, total_presses);
        checks++; if (busy !== 1) begin failures++; $display("FAIL empty_busy got=%0d exp=1", busy); end
        checks++; if (unsolved_count !== 16'(m_unsolved)) begin failures++; $display("FAIL empty_unsolved got=%0d exp=%0d", unsolved_count, m_unsolved); end
        checks++; if (total_presses !== m_total) begin failures++; $display("FAIL empty_total got=%0d exp=%0d", total_presses, m_total); end
`ifdef DAY10_RESULT_STREAM_EN
        checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL empty_pulses got=%0d exp=1", pulse_cnt - p0); end
        checks++; if (pulse_solved !== 1'b0 || pulse_presses !== '1) begin failures++; $display("FAIL empty_res got=%0d/%0b exp=%0d/0", pulse_presses, pulse_solved, NW'('1)); end
`endif
    endtask

    task automatic test_boundary();
        int busy, r;
        for (int j = 0; j < 16; j++) mm[j] = 16'($urandom);
        mm[0] = 16'b0001; mm[1] = 16'b0010;
        send(16'b0011, 2, mm, 1'b0, 1'b0, busy);
        r = ref_min(16'b0011, 2, mm);
        model_apply(r);
        $display("boundary_full: min=%0d busy=%0d total=%0d", r, busy, total_presses);
        checks++; if (total_presses !== m_total) begin failures++; $display("FAIL bnd_total got=%0d exp=%0d", total_presses, m_total); end
        checks++; if (busy !== 4) begin failures++; $display("FAIL bnd_busy got=%0d exp=4", busy); end
        mm[1] = 16'b0001;
        send(16'b0011, 2, mm, 1'b0, 1'b0, busy);
        r = ref_min(16'b0011, 2, mm);
        model_apply(r);
        $display("boundary_unsolvable: min=%0d unsolved=%0d total=%0d", r, unsolved_count, total_presses);
        checks++; if (unsolved_count !== 16'(m_unsolved)) begin failures++; $display("FAIL bnd_unsolved got=%0d exp=%0d", unsolved_count, m_unsolved); end
        checks++; if (total_presses !== m_total) begin failures++; $display("FAIL bnd_total2 got=%0d exp=%0d", total_presses, m_total); end
    endtask

    task automatic test_random();
        int busy, r, n;
        logic [15:0] t;
        for (int i = 0; i < 24; i++) begin
            n = $urandom_range(0, 8);
            for (int j = 0; j < 16; j++) mm[j] = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                t = '0;
                for (int j = 0; j < n; j++) if ($urandom_range(0, 1) == 1) t = t ^ mm[j];
            end else begin
                t = 16'($urandom_range(0, 63));
            end
            send(t, n, mm, i == 23, $urandom_range(0, 1) == 1, busy);
            r = ref_min(t, n, mm);
            model_apply(r);
            $display("random[%0d]: n=%0d t=%h min=%0d busy=%0d total=%0d unsolved=%0d",
                     i, n, t, r, busy, total_presses, unsolved_count);
            checks++; if (total_presses !== m_total) begin failures++; $display("FAIL rnd_total[%0d] got=%0d exp=%0d", i, total_presses, m_total); end
            checks++; if (unsolved_count !== 16'(m_unsolved)) begin failures++; $display("FAIL rnd_unsolved[%0d] got=%0d exp=%0d", i, unsolved_count, m_unsolved); end
            checks++; if (busy !== (1 << n)) begin failures++; $display("FAIL rnd_busy[%0d] got=%0d exp=%0d", i, busy, 1 << n); end
        end
        in_valid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rnd_done got=%0b exp=1", done); end
    endtask

    task automatic test_reset_midsearch();
        int busy, r;
        for (int j = 0; j < 16; j++) mm[j] = 16'($urandom);
        mm[0] = 16'b0001; mm[1] = 16'b0010;
        send(16'b0011, 2, mm, 1'b0, 1'b0, busy);
        model_apply(ref_min(16'b0011, 2, mm));
        checks++; if (total_presses !== m_total) begin failures++; $display("FAIL pre_total got=%0d exp=%0d", total_presses, m_total); end
        // Start a long search and cut it short.
        for (int j = 0; j < 16; j++) mm[j] = 16'($urandom_range(0, 63));
        in_target = 16'd5;
        in_btn_count = NW'(10);
        for (int j = 0; j < 16; j++) in_btn_masks[j*16 +: 16] = mm[j];
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        $display("midsearch_reset: total=%0d unsolved=%0d ready=%0b done=%0b", total_presses, unsolved_count, in_ready, done);
        checks++; if (total_presses !== 64'd0) begin failures++; $display("FAIL mid_total got=%0d exp=0", total_presses); end
        checks++; if (unsolved_count !== 16'd0) begin failures++; $display("FAIL mid_unsolved got=%0d exp=0", unsolved_count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%0b exp=0", in_ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_done got=%0b exp=0", done); end
        @(negedge clk);
        rst = 1'b0;
        m_total    = '0;
        m_unsolved = 0;
        #1;
        for (int j = 0; j < 16; j++) mm[j] = 16'($urandom_range(0, 63));
        send(mm[1] ^ mm[3], 5, mm, 1'b1, 1'b0, busy);
        r = ref_min(mm[1] ^ mm[3], 5, mm);
        model_apply(r);
        $display("after_reset: min=%0d busy=%0d total=%0d done=%0b", r, busy, total_presses, done);
        checks++; if (total_presses !== m_total) begin failures++; $display("FAIL post_total got=%0d exp=%0d", total_presses, m_total); end
        checks++; if (unsolved_count !== 16'(m_unsolved)) begin failures++; $display("FAIL post_unsolved got=%0d exp=%0d", unsolved_count, m_unsolved); end
        checks++; if (busy !== 32) begin failures++; $display("FAIL post_busy got=%0d exp=32", busy); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL post_done got=%0b exp=1", done); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_example1();
        test_reset();
        test_back_to_back();
        test_reset();
        test_zero_and_empty();
        test_boundary();
        test_random();
        test_reset();
        test_reset_midsearch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
